// File: rtl/sirius_exp_pkg.sv
// Shared definitions for the exception/eret commit controller: state encoding,
// flush-vector bit positions and the default drain bound.
package sirius_exp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } exp_state_e;

  localparam int FLUSH_IF  = 0;
  localparam int FLUSH_ID  = 1;
  localparam int FLUSH_EX  = 2;
  localparam int FLUSH_MEM = 3;

  localparam logic [3:0] FLUSH_ALL = 4'((1 << FLUSH_MEM) | (1 << FLUSH_EX) |
                                        (1 << FLUSH_ID)  | (1 << FLUSH_IF));

  localparam int DRAIN_MAX_DEF = 255;

endpackage

// File: rtl/exp_drain_timer.sv
// Saturating 8-bit cycle counter for the bus-drain phase; expired flags the
// cycle whose closing edge brings the count up to MAX.
module exp_drain_timer
  import sirius_exp_pkg::*;
#(
  parameter int MAX = DRAIN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic       expired,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= 8'd0;
    else if (enable && (count != 8'hFF))
      count <= count + 8'd1;
  end

  assign expired = (int'(count) + 1) >= MAX;

endmodule

// File: rtl/exception_commit_ctrl.sv
// Exception/eret commit sequencer: flush, wait for buses to drain, strobe CP0,
// then hold a PC redirect until fetch takes it.
module exception_commit_ctrl
  import sirius_exp_pkg::*;
#(
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exp_detect,
  input  logic        exp_detect_salve,
  input  logic        cp0_exp_en,
  input  logic        cp0_exl_clean,
  input  logic [31:0] exp_pc_address,
  input  logic        mem_busy,
  input  logic        ibus_busy,
  input  logic        redirect_ready,
  output logic [3:0]  flush,
  output logic        commit_busy,
  output logic        cp0_commit_wen,
  output logic        cp0_exl_clr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        commit_slave,
  output logic        drain_timeout
);

  exp_state_e  state, state_nxt;
  logic        accept;
  logic        bus_busy;
  logic        drain_expired;
  logic [7:0]  drain_cnt;
  logic        drain_stop;
  logic [31:0] lat_pc;
  logic        lat_exp_en;
  logic        lat_exl_clean;
  logic        lat_slave;

  assign accept   = (state == ST_IDLE) && exp_detect;
  assign bus_busy = mem_busy || ibus_busy;

  exp_drain_timer #(.MAX(DRAIN_MAX)) u_drain_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state == ST_DRAIN),
    .expired (drain_expired),
    .count   (drain_cnt)
  );

  // A saturated counter also forces the exit, so an oversized DRAIN_MAX can't stall here.
  assign drain_stop = drain_expired || (drain_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      lat_pc        <= 32'h0;
      lat_exp_en    <= 1'b0;
      lat_exl_clean <= 1'b0;
      lat_slave     <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_pc        <= exp_pc_address;
        lat_exp_en    <= cp0_exp_en;
        lat_exl_clean <= cp0_exl_clean;
        lat_slave     <= exp_detect_salve;
      end
      if ((state == ST_DRAIN) && bus_busy && drain_stop)
        drain_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (exp_detect) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (!bus_busy || drain_stop) state_nxt = ST_COMMIT;
      ST_COMMIT:   state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Flush fires in the detect cycle itself; everything else decodes from state.
  assign flush          = ((state != ST_IDLE) || exp_detect) ? FLUSH_ALL : 4'b0000;
  assign commit_busy    = (state != ST_IDLE);
  assign cp0_commit_wen = (state == ST_COMMIT) && lat_exp_en;
  assign cp0_exl_clr    = (state == ST_COMMIT) && lat_exl_clean;
  assign redirect_valid = (state == ST_REDIRECT);
  assign redirect_pc    = lat_pc;
  assign commit_slave   = lat_slave;

endmodule

// File: tb/tb_exception_commit_ctrl.sv
// Bench for exception_commit_ctrl: default-bound and DRAIN_MAX=4 instances
// share stimulus; vector table, directed corner sequences, random vs. model.
module tb_exception_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst, exp_detect, exp_detect_salve, cp0_exp_en, cp0_exl_clean;
  logic [31:0] exp_pc_address;
  logic        mem_busy, ibus_busy, redirect_ready;

  logic [3:0]  flush0, flush4;
  logic        busy0, busy4, wen0, wen4, clr0, clr4, rv0, rv4, slv0, slv4, tmo0, tmo4;
  logic [31:0] rpc0, rpc4;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  exception_commit_ctrl dut0 (
    .clk(clk), .rst(rst), .exp_detect(exp_detect), .exp_detect_salve(exp_detect_salve),
    .cp0_exp_en(cp0_exp_en), .cp0_exl_clean(cp0_exl_clean), .exp_pc_address(exp_pc_address),
    .mem_busy(mem_busy), .ibus_busy(ibus_busy), .redirect_ready(redirect_ready),
    .flush(flush0), .commit_busy(busy0), .cp0_commit_wen(wen0), .cp0_exl_clr(clr0),
    .redirect_valid(rv0), .redirect_pc(rpc0), .commit_slave(slv0), .drain_timeout(tmo0)
  );

  exception_commit_ctrl #(.DRAIN_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .exp_detect(exp_detect), .exp_detect_salve(exp_detect_salve),
    .cp0_exp_en(cp0_exp_en), .cp0_exl_clean(cp0_exl_clean), .exp_pc_address(exp_pc_address),
    .mem_busy(mem_busy), .ibus_busy(ibus_busy), .redirect_ready(redirect_ready),
    .flush(flush4), .commit_busy(busy4), .cp0_commit_wen(wen4), .cp0_exl_clr(clr4),
    .redirect_valid(rv4), .redirect_pc(rpc4), .commit_slave(slv4), .drain_timeout(tmo4)
  );

  typedef struct {
    bit          det, een, exl;
    logic [31:0] pc;
    logic [3:0]  e_flush;
    bit          e_busy, e_wen, e_clr, e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  function automatic vec_t v(bit d, bit e, bit x, logic [31:0] p, logic [3:0] ef,
                             bit eb, bit ew, bit ec, bit er, logic [31:0] ep);
    vec_t r;
    r.det = d; r.een = e; r.exl = x; r.pc = p;
    r.e_flush = ef; r.e_busy = eb; r.e_wen = ew; r.e_clr = ec; r.e_rv = er; r.e_rpc = ep;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Full output comparison for instance k (0 = default bound, 1 = DRAIN_MAX 4).
  task automatic chk_dut(int k, string t, logic [3:0] f, bit b, bit w, bit c, bit r,
                         logic [31:0] p, bit s, bit o);
    string n = $sformatf("%s.d%0d", t, k);
    if (k == 0) begin
      chk({n, ".flush"}, 32'(flush0), 32'(f)); chk({n, ".busy"}, 32'(busy0), 32'(b));
      chk({n, ".wen"},   32'(wen0),   32'(w)); chk({n, ".clr"},  32'(clr0),  32'(c));
      chk({n, ".rv"},    32'(rv0),    32'(r)); chk({n, ".rpc"},  rpc0,       p);
      chk({n, ".slave"}, 32'(slv0),   32'(s)); chk({n, ".tmo"},  32'(tmo0),  32'(o));
    end else begin
      chk({n, ".flush"}, 32'(flush4), 32'(f)); chk({n, ".busy"}, 32'(busy4), 32'(b));
      chk({n, ".wen"},   32'(wen4),   32'(w)); chk({n, ".clr"},  32'(clr4),  32'(c));
      chk({n, ".rv"},    32'(rv4),    32'(r)); chk({n, ".rpc"},  rpc4,       p);
      chk({n, ".slave"}, 32'(slv4),   32'(s)); chk({n, ".tmo"},  32'(tmo4),  32'(o));
    end
  endtask

  // Inputs change mid-cycle (negedge); outputs are sampled 1 time unit later.
  task automatic drv(bit r, bit d, bit s, bit e, bit x, logic [31:0] p, bit m, bit ib, bit y);
    @(negedge clk);
    rst = r; exp_detect = d; exp_detect_salve = s; cp0_exp_en = e; cp0_exl_clean = x;
    exp_pc_address = p; mem_busy = m; ibus_busy = ib; redirect_ready = y;
    #1;
  endtask

  // Reference model: a transaction is timestamped by its accept cycle; the commit
  // cycle is fixed once the drain outcome is known, redirect follows it.
  int          cyc;
  int          dmax [2] = '{255, 4};
  bit          m_act [2];
  int          m_acc [2];
  int          m_cmt [2];
  logic [31:0] m_pc  [2];
  bit          m_een [2], m_exl [2], m_slv [2], m_tmo [2];

  task automatic model_check(int k);
    bit dr = m_act[k] && (m_cmt[k] < 0);
    bit cm = m_act[k] && (m_cmt[k] == cyc);
    bit rd = m_act[k] && (m_cmt[k] >= 0) && (cyc > m_cmt[k]);
    chk_dut(k, "rnd", (m_act[k] || exp_detect) ? 4'hF : 4'h0, dr || cm || rd,
            cm && m_een[k], cm && m_exl[k], rd, m_pc[k], m_slv[k], m_tmo[k]);
  endtask

  task automatic model_edge(int k);
    if (rst) begin
      m_act[k] = 0; m_pc[k] = 0; m_een[k] = 0; m_exl[k] = 0; m_slv[k] = 0; m_tmo[k] = 0;
    end else if (!m_act[k]) begin
      if (exp_detect) begin
        m_act[k] = 1; m_acc[k] = cyc; m_cmt[k] = -1; m_pc[k] = exp_pc_address;
        m_een[k] = cp0_exp_en; m_exl[k] = cp0_exl_clean; m_slv[k] = exp_detect_salve;
      end
    end else if (m_cmt[k] < 0) begin
      if (!mem_busy && !ibus_busy) m_cmt[k] = cyc + 1;
      else if (cyc - m_acc[k] >= dmax[k]) begin m_cmt[k] = cyc + 1; m_tmo[k] = 1; end
    end else if ((cyc > m_cmt[k]) && redirect_ready) begin
      m_act[k] = 0;
    end
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = v(1, 1, 0, 32'hBFC0_0380, 4'hF, 0, 0, 0, 0, 32'h0);
    tbl[1] = v(0, 0, 0, 32'h0,         4'hF, 1, 0, 0, 0, 32'hBFC0_0380);
    tbl[2] = v(0, 0, 0, 32'h0,         4'hF, 1, 1, 0, 0, 32'hBFC0_0380);
    tbl[3] = v(0, 0, 0, 32'h0,         4'hF, 1, 0, 0, 1, 32'hBFC0_0380);
    tbl[4] = v(1, 0, 1, 32'h8000_1234, 4'hF, 0, 0, 0, 0, 32'hBFC0_0380);
    tbl[5] = v(0, 0, 0, 32'h0,         4'hF, 1, 0, 0, 0, 32'h8000_1234);
    tbl[6] = v(0, 0, 0, 32'h0,         4'hF, 1, 0, 1, 0, 32'h8000_1234);
    tbl[7] = v(0, 0, 0, 32'h0,         4'hF, 1, 0, 0, 1, 32'h8000_1234);
    tbl[8] = v(0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 0, 32'h8000_1234);

    // Reset, with a detect in the reset cycle that must be discarded.
    drv(1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    drv(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk_dut(k, "reset", 4'h0, 0, 0, 0, 0, 32'h0, 0, 0);

    // Exception path then eret path, back to back.
    for (int i = 0; i < 9; i++) begin
      drv(0, tbl[i].det, 0, tbl[i].een, tbl[i].exl, tbl[i].pc, 0, 0, 1);
      for (int k = 0; k < 2; k++)
        chk_dut(k, $sformatf("tbl%0d", i), tbl[i].e_flush, tbl[i].e_busy, tbl[i].e_wen,
                tbl[i].e_clr, tbl[i].e_rv, tbl[i].e_rpc, 0, 0);
    end

    // mem_busy for 5 cycles: default bound commits at N+7, DRAIN_MAX=4 times out.
    drv(0, 1, 0, 1, 0, 32'hA0A0_0004, 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      drv(0, 0, 0, 0, 0, 32'h0, i <= 5, 0, 1);
      chk($sformatf("drain.d0.wen@%0d", i), 32'(wen0), 32'(i == 7));
      chk($sformatf("drain.d0.rv@%0d", i),  32'(rv0),  32'(i == 8));
      chk($sformatf("drain.d0.busy@%0d", i), 32'(busy0), 32'(i <= 8));
      chk($sformatf("drain.d4.wen@%0d", i), 32'(wen4), 32'(i == 5));
      chk($sformatf("drain.d4.tmo@%0d", i), 32'(tmo4), 32'(i >= 5));
      if (i == 6) chk("drain.d4.rpc", rpc4, 32'hA0A0_0004);
      if (i == 7) chk("drain.d4.busy", 32'(busy4), 32'(0));
    end
    chk("drain.d0.tmo", 32'(tmo0), 32'(0));

    // Backpressure, plus a second detect with another target while busy.
    drv(0, 1, 0, 1, 0, 32'h1111_2222, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      drv(0, i == 4, 0, 0, 1, (i == 4) ? 32'hDEAD_BEEF : 32'h0, 0, 0, i == 6);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("bp.d%0d.rv@%0d", k, i), 32'(k == 0 ? rv0 : rv4), 32'(i >= 3 && i <= 6));
        chk($sformatf("bp.d%0d.rpc@%0d", k, i), k == 0 ? rpc0 : rpc4, 32'h1111_2222);
      end
      if (i == 2) chk("bp.clr_ignored", 32'(clr0), 32'(0));
    end
    chk("bp.tmo_sticky", 32'(tmo4), 32'(1));

    // Reset while in REDIRECT, with a detect in the reset cycle.
    drv(0, 1, 1, 1, 1, 32'h1234_5678, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("rstmid.slave", 32'(slv0), 32'(1));
    drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("rstmid.rv", 32'(rv0), 32'(1));
    drv(1, 1, 1, 1, 1, 32'h5555_AAAA, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk_dut(k, "rstmid", 4'h0, 0, 0, 0, 0, 32'h0, 0, 0);

    // Normal completion after reset; slave flag lasts until next accepted detect.
    drv(0, 1, 1, 1, 0, 32'h0BAD_F00D, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 1);
      chk($sformatf("slave@%0d", i), 32'(slv0), 32'(1));
    end
    chk("post.rpc", rpc0, 32'h0BAD_F00D);
    chk("post.rv", 32'(rv0), 32'(1));
    drv(0, 1, 0, 1, 0, 32'h0000_0040, 0, 0, 1);
    chk("slave.hold", 32'(slv0), 32'(1));
    chk("post.busy", 32'(busy0), 32'(0));
    drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 1);
    chk("slave.clear", 32'(slv0), 32'(0));
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 0, 32'h0, 0, 0, 1);

    // Random traffic against the reference model.
    drv(1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_acc[k] = 0; m_cmt[k] = -1; m_pc[k] = 0;
      m_een[k] = 0; m_exl[k] = 0; m_slv[k] = 0; m_tmo[k] = 0;
    end
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
          1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
      for (int k = 0; k < 2; k++) model_check(k);
      for (int k = 0; k < 2; k++) model_edge(k);
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/exception_commit_ctrl.md
EXCEPTION_COMMIT_CTRL -- requirements
Module: exception_commit_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have the following inputs:
- exp_detect input 1: exception or eret resolved this cycle.
- exp_detect_salve input 1: the exception belongs to the slave-issue instruction.
- cp0_exp_en input 1: a CP0 exception write is required.
- cp0_exl_clean input 1: eret, so EXL is to be cleared.
- exp_pc_address input 32: redirect target.
- mem_busy input 1: data-bus transaction outstanding.
- ibus_busy input 1: instruction-bus transaction outstanding.
- redirect_ready input 1: fetch accepts the redirect.
REQ-003 SHALL have the following outputs:
- flush output 4: flush of {MEM,EX,ID,IF}, bit 3 = MEM.
- commit_busy output 1: controller not in IDLE.
- cp0_commit_wen output 1: one-cycle CP0 exception-write strobe.
- cp0_exl_clr output 1: one-cycle EXL-clear strobe.
- redirect_valid output 1: PC redirect request.
- redirect_pc output 32: latched target.
- commit_slave output 1: latched exp_detect_salve.
- drain_timeout output 1: sticky drain-timeout flag.
REQ-004 SHALL have parameter DRAIN_MAX, default 255, giving the maximum number of cycles spent in DRAIN.

Function
REQ-005 SHALL implement states IDLE, DRAIN, COMMIT and REDIRECT.
REQ-006 When exp_detect=1 in IDLE, SHALL assert flush=4'b1111 combinationally in the same cycle N and SHALL enter DRAIN at cycle N+1.
REQ-007 On that same edge, SHALL latch exp_pc_address, cp0_exp_en, cp0_exl_clean and exp_detect_salve.
REQ-008 SHALL hold flush=4'b1111 in DRAIN, COMMIT and REDIRECT, and flush=0 in IDLE when exp_detect=0.
REQ-009 DRAIN SHALL last at least one cycle.
REQ-010 In DRAIN, SHALL go to COMMIT on the edge where mem_busy=0 and ibus_busy=0.
REQ-011 SHALL keep an 8-bit drain counter that clears on entry to DRAIN and increments each cycle spent in DRAIN.
REQ-012 If the drain counter reaches DRAIN_MAX while still busy, SHALL set drain_timeout=1 and go to COMMIT.
REQ-013 drain_timeout SHALL stay set until rst.
REQ-014 COMMIT SHALL last exactly one cycle, during which cp0_commit_wen equals the latched cp0_exp_en and cp0_exl_clr equals the latched cp0_exl_clean.
REQ-015 cp0_commit_wen and cp0_exl_clr SHALL be 0 in every other state.
REQ-016 REDIRECT SHALL assert redirect_valid=1 with redirect_pc equal to the latched target, and SHALL hold both stable until redirect_ready=1.
REQ-017 On the edge where redirect_ready=1 in REDIRECT, SHALL return to IDLE, so redirect_valid is 0 in the next cycle.
REQ-018 Best-case latency SHALL be: detect at N, COMMIT at N+2, redirect_valid at N+3, IDLE at N+4 with redirect_ready tied to 1.
REQ-019 SHALL ignore exp_detect while not in IDLE, leaving the latched values unchanged because the pipeline is already flushed.
REQ-020 SHALL accept a new exp_detect in the IDLE cycle directly after REDIRECT.
REQ-021 commit_busy SHALL equal (state != IDLE).
REQ-022 commit_slave SHALL hold its latched value until the next accepted detect.
REQ-023 redirect_pc SHALL be a straight 32-bit copy with no arithmetic.
REQ-024 The drain counter SHALL saturate and never wrap.

Reset
REQ-025 When rst=1 at a clk edge, SHALL go to IDLE from any state, including mid-DRAIN and mid-REDIRECT.
REQ-026 On reset, SHALL clear the drain counter, latched target, latched flags and drain_timeout.
REQ-027 In the cycle after reset, all outputs SHALL be 0 (flush=4'b0000, redirect_pc=32'h0).
REQ-028 An exp_detect sampled in the same cycle as rst=1 SHALL be discarded.

Structure
REQ-029 The state enum (2-bit), the flush-vector bit indices and the DRAIN_MAX default SHALL live in the shared package sirius_exp_pkg.
REQ-030 The drain counter SHALL be a single sub-module, exp_drain_timer, with inputs clear and enable and outputs expired and count.
REQ-031 The block SHALL be purely synchronous, with registered state and combinational outputs decoded from state and latches, except the same-cycle flush of REQ-006.

Verification
REQ-032 Exception path: exp_detect=1, cp0_exp_en=1, exp_pc_address=32'hBFC0_0380, buses idle, redirect_ready=1 -> flush=4'hF at N, cp0_commit_wen pulse at N+2, redirect_valid with 32'hBFC0_0380 at N+3, IDLE at N+4.
REQ-033 Eret path: cp0_exp_en=0, cp0_exl_clean=1, target 32'h8000_1234 -> cp0_exl_clr pulse only, cp0_commit_wen stays 0, redirect to 32'h8000_1234.
REQ-034 Drain: mem_busy held 1 for 5 cycles after detect -> COMMIT at N+7; with mem_busy stuck at 1 and DRAIN_MAX=4 -> drain_timeout=1 and COMMIT after 4 DRAIN cycles.
REQ-035 Backpressure: redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable for 4 cycles; a second exp_detect with a different target during this window is ignored.
REQ-036 Reset mid-operation: rst asserted in REDIRECT -> IDLE next cycle with all outputs 0; a subsequent detect completes normally.
REQ-037 Slave exception: exp_detect_salve=1 -> commit_slave=1 from N+1 until the next accepted detect with salve=0.
